// File: rtl/multiplier_pkg.sv
// Control types shared by the Montgomery multiplier and domain converter.
package multiplier_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      STEP = 2'd2,
      DONE = 2'd3
   } conv_state_e;

endpackage : multiplier_pkg

// File: rtl/params_pkg.sv
// Shared datapath parameters for the Montgomery arithmetic blocks.
package params_pkg;

   localparam int unsigned DATA_LENGTH    = 24;
   localparam int unsigned MODULUS        = 8380417;
   localparam int unsigned MODULUS_LENGTH = 23;
   localparam int unsigned MONT_CNT_W     = $clog2(DATA_LENGTH + 1);

endpackage : params_pkg

// File: rtl/montgomery_conv_step.sv
// One conversion iteration: modular doubling (into R domain) or, with
// MONT_CONV_FROM_EN, modular halving (out of R domain). Requires i_v < i_m.
module montgomery_conv_step #(
   parameter int unsigned DATA_LENGTH = params_pkg::DATA_LENGTH
) (
   input  logic [DATA_LENGTH-1:0] i_v,
   input  logic [DATA_LENGTH-1:0] i_m,
`ifdef MONT_CONV_FROM_EN
   input  logic                   i_dir,
`endif
   output logic [DATA_LENGTH-1:0] o_v_next_c
);

   localparam int unsigned EXT_W = DATA_LENGTH + 1;

   logic [EXT_W-1:0]       w_m_ext;
   logic [EXT_W-1:0]       w_dbl;
   logic [DATA_LENGTH-1:0] w_dbl_res;

   assign w_m_ext = {1'b0, i_m};
   assign w_dbl   = {i_v, 1'b0};

   // 2v < 2m, so a single conditional subtract brings it back below m
   always_comb begin
      w_dbl_res = DATA_LENGTH'(w_dbl);
      if (w_dbl >= w_m_ext) begin
         w_dbl_res = DATA_LENGTH'(w_dbl - w_m_ext);
      end
   end

`ifdef MONT_CONV_FROM_EN
   logic [EXT_W-1:0]       w_half_sum;
   logic [DATA_LENGTH-1:0] w_half_res;

   // odd m makes v + m even whenever v is odd, so the shift is exact
   assign w_half_sum = {1'b0, i_v} + (i_v[0] ? w_m_ext : EXT_W'(0));
   assign w_half_res = DATA_LENGTH'(w_half_sum >> 1);

   assign o_v_next_c = i_dir ? w_half_res : w_dbl_res;
`else
   assign o_v_next_c = w_dbl_res;
`endif

endmodule : montgomery_conv_step

// File: rtl/montgomery_domain_conv.sv
// Serial Montgomery-domain converter: result = y * 2^m_bl mod m, one doubling per
// cycle. Defining MONT_CONV_FROM_EN adds dir_i and the reverse (halving) direction.
module montgomery_domain_conv
   import multiplier_pkg::*;
#(
   parameter int unsigned DATA_LENGTH = params_pkg::DATA_LENGTH
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [DATA_LENGTH-1:0] y_i,
   input  logic [DATA_LENGTH-1:0] m_i,
   input  logic [DATA_LENGTH-1:0] m_bl_i,
`ifdef MONT_CONV_FROM_EN
   input  logic                   dir_i,
`endif
   output logic [DATA_LENGTH-1:0] result_o,
   output logic                   valid_o,
   output logic                   busy_o
);

   localparam int unsigned CNT_W = $clog2(DATA_LENGTH + 1);

   conv_state_e            r_state;
   logic [DATA_LENGTH-1:0] r_v;
   logic [DATA_LENGTH-1:0] r_m;
   logic [CNT_W-1:0]       r_cnt;
   logic [DATA_LENGTH-1:0] r_result;
   logic                   r_valid;
   logic                   r_busy;

   conv_state_e            w_state_nxt;
   logic [DATA_LENGTH-1:0] w_v_nxt;
   logic [DATA_LENGTH-1:0] w_m_nxt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic [DATA_LENGTH-1:0] w_result_nxt;
   logic                   w_valid_nxt;
   logic                   w_busy_nxt;
   logic [CNT_W-1:0]       w_cnt_sat;
   logic [DATA_LENGTH-1:0] w_step_v;

`ifdef MONT_CONV_FROM_EN
   logic r_dir;
   logic w_dir_nxt;
`endif

   // iteration count never exceeds the operand width
   assign w_cnt_sat = (m_bl_i > DATA_LENGTH'(DATA_LENGTH)) ? CNT_W'(DATA_LENGTH)
                                                           : CNT_W'(m_bl_i);

   montgomery_conv_step #(
      .DATA_LENGTH (DATA_LENGTH)
   ) u_step (
      .i_v        (r_v),
      .i_m        (r_m),
`ifdef MONT_CONV_FROM_EN
      .i_dir      (r_dir),
`endif
      .o_v_next_c (w_step_v)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_v_nxt      = r_v;
      w_m_nxt      = r_m;
      w_cnt_nxt    = r_cnt;
      w_result_nxt = r_result;
      w_valid_nxt  = 1'b0;
`ifdef MONT_CONV_FROM_EN
      w_dir_nxt    = r_dir;
`endif
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_state_nxt = LOAD;
               w_v_nxt     = y_i;
               w_m_nxt     = m_i;
               w_cnt_nxt   = w_cnt_sat;
`ifdef MONT_CONV_FROM_EN
               w_dir_nxt   = dir_i;
`endif
            end
         end
         LOAD: begin
            // operand may be up to 2m-1; fold it into [0, m)
            if (r_v >= r_m) begin
               w_v_nxt = r_v - r_m;
            end
            w_state_nxt = (r_cnt == CNT_W'(0)) ? DONE : STEP;
         end
         STEP: begin
            w_v_nxt   = w_step_v;
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_result_nxt = r_v;
            w_valid_nxt  = 1'b1;
            w_state_nxt  = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt == LOAD) || (w_state_nxt == STEP);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_v      <= '0;
         r_m      <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
`ifdef MONT_CONV_FROM_EN
         r_dir    <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_v      <= w_v_nxt;
         r_m      <= w_m_nxt;
         r_cnt    <= w_cnt_nxt;
         r_result <= w_result_nxt;
         r_valid  <= w_valid_nxt;
         r_busy   <= w_busy_nxt;
`ifdef MONT_CONV_FROM_EN
         r_dir    <= w_dir_nxt;
`endif
      end
   end

   assign result_o = r_result;
   assign valid_o  = r_valid;
   assign busy_o   = r_busy;

endmodule : montgomery_domain_conv

// File: tb/tb_montgomery_domain_conv.sv
// Directed self-checking bench for montgomery_domain_conv (both builds of MONT_CONV_FROM_EN).
module tb_montgomery_domain_conv;

   localparam int unsigned DL = params_pkg::DATA_LENGTH;
   localparam logic [DL-1:0] M_BIG   = DL'(8380417);
   localparam logic [DL-1:0] M_SMALL = DL'(13);

   logic          clk_i;
   logic          rst_i;
   logic          start_i;
   logic [DL-1:0] y_i;
   logic [DL-1:0] m_i;
   logic [DL-1:0] m_bl_i;
   logic          dir_i;
   logic [DL-1:0] result_o;
   logic          valid_o;
   logic          busy_o;

   int n_checks;
   int n_errors;

   montgomery_domain_conv #(.DATA_LENGTH(DL)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .y_i      (y_i),
      .m_i      (m_i),
      .m_bl_i   (m_bl_i),
`ifdef MONT_CONV_FROM_EN
      .dir_i    (dir_i),
`endif
      .result_o (result_o),
      .valid_o  (valid_o),
      .busy_o   (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Launch one job and wait (bounded) for its valid pulse; lat = edges after the start edge.
   task automatic run_job(input logic [DL-1:0] y, input logic [DL-1:0] m,
                          input logic [DL-1:0] mbl, input logic dir,
                          output logic [DL-1:0] res, output int lat);
      y_i = y; m_i = m; m_bl_i = mbl; dir_i = dir; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      res = '0;
      lat = -1;
      for (int c = 1; c <= 100 && lat < 0; c++) begin
         @(posedge clk_i); #1;
         if (valid_o === 1'b1) begin
            lat = c;
            res = result_o;
         end
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b0; y_i = '0; m_i = '0; m_bl_i = '0; dir_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      n_checks++; if (result_o !== '0) begin n_errors++; $display("FAIL reset_result got=%0h exp=0", result_o); end
      n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_forward_big();
      logic [DL-1:0] res; int lat;
      logic [DL-1:0] ys [3];
      logic [DL-1:0] ex [3];
      ys = '{DL'(1), DL'(2), DL'(0)};
      ex = '{DL'('h1FFF), DL'('h3FFE), DL'(0)};
      for (int i = 0; i < 3; i++) begin
         run_job(ys[i], M_BIG, DL'(23), 1'b0, res, lat);
         n_checks++; if (res !== ex[i]) begin n_errors++; $display("FAIL fwd_big_result y=%0d got=%0h exp=%0h", ys[i], res, ex[i]); end
         n_checks++; if (lat !== 25) begin n_errors++; $display("FAIL fwd_big_latency y=%0d got=%0d exp=25", ys[i], lat); end
      end
   endtask

   task automatic test_forward_small();
      logic [DL-1:0] res; int lat;
      logic [DL-1:0] ys [3];
      logic [DL-1:0] ex [3];
      ys = '{DL'(5), DL'(12), DL'(18)};
      ex = '{DL'(2), DL'(10), DL'(2)};
      for (int i = 0; i < 3; i++) begin
         run_job(ys[i], M_SMALL, DL'(4), 1'b0, res, lat);
         n_checks++; if (res !== ex[i]) begin n_errors++; $display("FAIL fwd_small_result y=%0d got=%0d exp=%0d", ys[i], res, ex[i]); end
         n_checks++; if (lat !== 6) begin n_errors++; $display("FAIL fwd_small_latency y=%0d got=%0d exp=6", ys[i], lat); end
      end
   endtask

`ifdef MONT_CONV_FROM_EN
   task automatic test_reverse();
      logic [DL-1:0] res; int lat;
      run_job(DL'(2), M_SMALL, DL'(4), 1'b1, res, lat);
      n_checks++; if (res !== DL'(5)) begin n_errors++; $display("FAIL rev_small_2 got=%0d exp=5", res); end
      n_checks++; if (lat !== 6) begin n_errors++; $display("FAIL rev_small_latency got=%0d exp=6", lat); end
      run_job(DL'(10), M_SMALL, DL'(4), 1'b1, res, lat);
      n_checks++; if (res !== DL'(12)) begin n_errors++; $display("FAIL rev_small_10 got=%0d exp=12", res); end
      run_job(DL'('h1FFF), M_BIG, DL'(23), 1'b1, res, lat);
      n_checks++; if (res !== DL'(1)) begin n_errors++; $display("FAIL rev_big got=%0h exp=1", res); end
      n_checks++; if (lat !== 25) begin n_errors++; $display("FAIL rev_big_latency got=%0d exp=25", lat); end
   endtask
`endif

   task automatic test_mbl_bounds();
      logic [DL-1:0] res; int lat;
      run_job(DL'(20), M_SMALL, DL'(0), 1'b0, res, lat);
      n_checks++; if (res !== DL'(7)) begin n_errors++; $display("FAIL mbl0_result got=%0d exp=7", res); end
      n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL mbl0_latency got=%0d exp=2", lat); end
      // 2 has order 12 mod 13, so 5*2^24 mod 13 = 5
      run_job(DL'(5), M_SMALL, DL'(DL + 5), 1'b0, res, lat);
      n_checks++; if (res !== DL'(5)) begin n_errors++; $display("FAIL mbl_sat_result got=%0d exp=5", res); end
      n_checks++; if (lat !== int'(DL) + 2) begin n_errors++; $display("FAIL mbl_sat_latency got=%0d exp=%0d", lat, DL + 2); end
   endtask

   task automatic test_busy_timing();
      y_i = DL'(5); m_i = M_SMALL; m_bl_i = DL'(4); dir_i = 1'b0; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL busy_after_start got=%b exp=1", busy_o); end
      repeat (4) @(posedge clk_i);
      #1;
      n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL busy_last_step got=%b exp=1", busy_o); end
      @(posedge clk_i); #1;
      n_checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin n_errors++; $display("FAIL busy_done got=%b/%b exp=0/0", busy_o, valid_o); end
      @(posedge clk_i); #1;
      n_checks++; if (valid_o !== 1'b1 || result_o !== DL'(2)) begin n_errors++; $display("FAIL busy_valid got=%b/%0d exp=1/2", valid_o, result_o); end
      @(posedge clk_i); #1;
      n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL valid_one_cycle got=%b exp=0", valid_o); end
   endtask

   task automatic test_back_to_back();
      logic [DL-1:0] res; int lat;
      run_job(DL'(5), M_SMALL, DL'(4), 1'b0, res, lat);
      run_job(DL'(12), M_SMALL, DL'(4), 1'b0, res, lat);
      n_checks++; if (res !== DL'(10)) begin n_errors++; $display("FAIL b2b_result got=%0d exp=10", res); end
      n_checks++; if (lat !== 6) begin n_errors++; $display("FAIL b2b_latency got=%0d exp=6", lat); end
   endtask

   task automatic test_start_ignored();
      int pulses; logic [DL-1:0] res; int unstable;
      pulses = 0; res = '0; unstable = 0;
      y_i = DL'(5); m_i = M_SMALL; m_bl_i = DL'(4); dir_i = 1'b0; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      y_i = DL'(12); start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0; y_i = '0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk_i); #1;
         if (valid_o === 1'b1) begin pulses++; res = result_o; end
         else if (pulses > 0 && result_o !== DL'(2)) unstable++;
      end
      n_checks++; if (pulses !== 1) begin n_errors++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
      n_checks++; if (res !== DL'(2)) begin n_errors++; $display("FAIL ignore_result got=%0d exp=2", res); end
      n_checks++; if (unstable !== 0) begin n_errors++; $display("FAIL result_hold got=%0d changes exp=0", unstable); end
   endtask

   task automatic test_reset_mid();
      int pulses; logic [DL-1:0] res; int lat;
      pulses = 0;
      y_i = DL'(1); m_i = M_BIG; m_bl_i = DL'(23); dir_i = 1'b0; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (12) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      n_checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== '0) begin
         n_errors++; $display("FAIL mid_reset got busy=%b valid=%b result=%0h exp=0/0/0", busy_o, valid_o, result_o);
      end
      for (int c = 0; c < 30; c++) begin
         @(posedge clk_i); #1;
         if (valid_o === 1'b1) pulses++;
      end
      n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL aborted_pulse got=%0d exp=0", pulses); end
      run_job(DL'(2), M_BIG, DL'(23), 1'b0, res, lat);
      n_checks++; if (res !== DL'('h3FFE)) begin n_errors++; $display("FAIL post_reset_result got=%0h exp=3ffe", res); end
      n_checks++; if (lat !== 25) begin n_errors++; $display("FAIL post_reset_latency got=%0d exp=25", lat); end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_forward_big();
      test_forward_small();
`ifdef MONT_CONV_FROM_EN
      test_reverse();
`endif
      test_mbl_bounds();
      test_busy_timing();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_montgomery_domain_conv

// File: doc/montgomery_domain_conv.md
# montgomery_domain_conv

Serial operand converter for the Montgomery datapath: maps a standard-form residue y into Montgomery form y·R mod m, with R = 2^m_bl. It is the producer of the pre-converted y operand that `montgomery_serialized` consumes, so operands no longer need offline conversion. It computes one modular doubling per cycle. A compile-time option adds the reverse conversion y·R⁻¹ mod m, computed by modular halving.

## Interface
- DATA_LENGTH, default params_pkg::DATA_LENGTH: operand and result width.
- clk_i  in  1  rising-edge clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  starts a conversion; sampled only in IDLE.
- y_i  in  DATA_LENGTH  operand; precondition y_i < 2·m_i.
- m_i  in  DATA_LENGTH  modulus; precondition m_i ≥ 2 (odd when the reverse direction is used).
- m_bl_i  in  DATA_LENGTH  exponent of R; values above DATA_LENGTH saturate to DATA_LENGTH.
- dir_i  in  1  only with MONT_CONV_FROM_EN: 0 = into Montgomery form, 1 = out of Montgomery form.
- result_o  out  DATA_LENGTH  converted value; held until the next conversion completes.
- valid_o  out  1  one-cycle pulse when result_o is updated.
- busy_o  out  1  high in LOAD and STEP.

## Operation
- FSM states: IDLE, LOAD, STEP, DONE. The state enum is conv_state_e.
- IDLE: a posedge with start_i=1 moves to LOAD. At that edge y_i, m_i, m_bl_i (and dir_i) are captured.
- LOAD (1 cycle):
  - v ← (y ≥ m) ? y − m : y, so v < m.
  - cnt ← min(m_bl, DATA_LENGTH).
  - If cnt = 0, go to DONE; otherwise go to STEP.
- STEP, one iteration per cycle:
  - Forward: t = 2v (DATA_LENGTH+1 bits); v ← (t ≥ m) ? t − m : t.
  - Reverse: t = v + (v[0] ? m : 0) (DATA_LENGTH+1 bits); v ← t >> 1.
  - cnt ← cnt − 1. When cnt reaches 1, go to DONE, with the final v registered into result_o.
- DONE (1 cycle): valid_o=1, then return to IDLE.
- Invariant: v < m after every step. All intermediates are DATA_LENGTH+1 bits; overflow is impossible.
- start_i outside IDLE is ignored and not queued. start_i held high in DONE does not retrigger; the next start is sampled in IDLE.
- Precondition violation (y ≥ 2m, or even m in reverse mode) gives an undefined result_o value, but the FSM timing is unchanged.

## Timing
- Reset values: result_o=0, valid_o=0, busy_o=0, state=IDLE, internal v and cnt = 0.
- Let the start sample edge be E0:
  - busy_o is high from E0+1 through the edge that enters DONE.
  - valid_o is high for exactly the cycle following edge E0+m_bl+2.
  - Latency is m_bl+2 cycles.
  - m_bl=0 gives latency 2 and result = y mod m.
- Back-to-back: the earliest next start is sampled on the edge leaving DONE+IDLE, i.e. one IDLE cycle between jobs.
- rst_i mid-operation: on the next edge the FSM returns to IDLE and all outputs clear. No valid_o pulse is emitted for the aborted job.
- Inputs may change after E0 without effect.

## Configuration
- MONT_CONV_FROM_EN defined:
  - the dir_i port exists;
  - STEP muxes between doubling and halving;
  - dir is captured at E0.
- MONT_CONV_FROM_EN undefined:
  - no dir_i port and no halving logic;
  - the block converts into Montgomery form only.
- Latency is identical in both builds.

## Structure
- params_pkg: DATA_LENGTH, MODULUS, MODULUS_LENGTH (already present); add MONT_CNT_W = $clog2(DATA_LENGTH+1).
- multiplier_pkg: conv_state_e enum {IDLE, LOAD, STEP, DONE}.
- Sub-module montgomery_conv_step: purely combinational single iteration (v, m, dir → v_next). Doubling and halving are each one adder plus compare/mux. It is instantiated once inside the FSM.

## Test plan
- Forward, m=8380417, m_bl=23:
  - y=1 → result_o=0x1FFF;
  - y=2 → 0x3FFE;
  - y=0 → 0;
  - valid_o is seen exactly 25 cycles after the start edge.
- Forward, m=13, m_bl=4: y=5 → 2; y=12 → 10; y=18 (≥m, pre-reduced) → 2.
- Reverse (MONT_CONV_FROM_EN), m=13, m_bl=4: y=2 → 5; y=10 → 12. Reverse, m=8380417, m_bl=23: y=0x1FFF → 1.
- m_bl=0, m=13, y=20 → result_o=7 with latency 2. m_bl=DATA_LENGTH+5 behaves exactly as m_bl=DATA_LENGTH.
- start_i pulsed mid-job → ignored: only one valid_o pulse and the result of the first job. result_o is stable until the next completion.
- rst_i asserted halfway through the m=8380417 job → next cycle busy_o=0, valid_o=0, result_o=0. A fresh start afterwards produces the correct result.
